// File: rtl/button_conditioner_if.sv
// Key inputs and conditioned outputs of the button conditioner.
// The slave side is the conditioner; the master side drives the keys.
interface button_conditioner_if;
  logic       set_mode_key_n;
  logic       inc_hour_key_n;
  logic       inc_min_key_n;
  logic       confirm_key_n;
  logic       set_mode_button_export;
  logic       inc_hour_button_export;
  logic       inc_min_button_export;
  logic       confirm_button_export;
  logic [3:0] btn_level;

  modport master (
    output set_mode_key_n, inc_hour_key_n, inc_min_key_n, confirm_key_n,
    input  set_mode_button_export, inc_hour_button_export, inc_min_button_export,
           confirm_button_export, btn_level
  );

  modport slave (
    input  set_mode_key_n, inc_hour_key_n, inc_min_key_n, confirm_key_n,
    output set_mode_button_export, inc_hour_button_export, inc_min_button_export,
           confirm_button_export, btn_level
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes, debounces and edge-detects four push-buttons; the hour and minute keys
// additionally auto-repeat while held.
module button_conditioner #(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100
) (
  input logic                 clk_clk,
  input logic                 reset_reset_n,
  button_conditioner_if.slave bus
);

  localparam int unsigned DbCyc  = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned RdCyc  = CLK_HZ / 1000 * REPEAT_DELAY_MS;
  localparam int unsigned RrCyc  = CLK_HZ / 1000 * REPEAT_RATE_MS;
  localparam int unsigned DbW    = $clog2(DbCyc + 1);
  localparam int unsigned RepMax = (RdCyc > RrCyc) ? RdCyc : RrCyc;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_state_e;

  // Bit order {set_mode, inc_hour, inc_min, confirm}.
  logic [3:0] key_n;
  logic [3:0] level;
  logic [3:0] pulse;

  assign key_n = {bus.set_mode_key_n, bus.inc_hour_key_n, bus.inc_min_key_n,
                  bus.confirm_key_n};

  for (genvar g = 0; g < 4; g++) begin : g_key
    logic           sync1_q, sync2_q;
    logic           deb_q, deb_d;
    logic           deb_dly_q;
    logic           pulse_q, pulse_d;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           press;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        sync1_q   <= 1'b1;
        sync2_q   <= 1'b1;
        deb_q     <= 1'b0;
        deb_dly_q <= 1'b0;
        db_cnt_q  <= '0;
        pulse_q   <= 1'b0;
      end else begin
        sync1_q   <= key_n[g];
        sync2_q   <= sync1_q;
        deb_q     <= deb_d;
        deb_dly_q <= deb_q;
        db_cnt_q  <= db_cnt_d;
        pulse_q   <= pulse_d;
      end
    end

    // Count consecutive cycles where the pressed level disagrees with the debounced state.
    always_comb begin
      deb_d    = deb_q;
      db_cnt_d = '0;
      if (~sync2_q != deb_q) begin
        if (db_cnt_q == DbW'(DbCyc - 1)) begin
          deb_d = ~deb_q;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
    end

    assign press = deb_q & ~deb_dly_q;

    if (g == 1 || g == 2) begin : g_rep
      rep_state_e      state_q, state_d;
      logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
      logic            fire;

      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
          state_q   <= StIdle;
          rep_cnt_q <= '0;
        end else begin
          state_q   <= state_d;
          rep_cnt_q <= rep_cnt_d;
        end
      end

      // A debounced release wins over any pending repeat on the same edge.
      always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        fire      = 1'b0;
        case (state_q)
          StIdle: begin
            rep_cnt_d = '0;
            if (press) state_d = StDelay;
          end
          StDelay: begin
            if (!deb_d) begin
              state_d   = StIdle;
              rep_cnt_d = '0;
            end else if (rep_cnt_q == RepW'(RdCyc - 1)) begin
              fire      = 1'b1;
              state_d   = StRepeat;
              rep_cnt_d = '0;
            end else begin
              rep_cnt_d = rep_cnt_q + 1'b1;
            end
          end
          StRepeat: begin
            if (!deb_d) begin
              state_d   = StIdle;
              rep_cnt_d = '0;
            end else if (rep_cnt_q == RepW'(RrCyc - 1)) begin
              fire      = 1'b1;
              rep_cnt_d = '0;
            end else begin
              rep_cnt_d = rep_cnt_q + 1'b1;
            end
          end
          default: begin
            state_d   = StIdle;
            rep_cnt_d = '0;
          end
        endcase
      end

      assign pulse_d = press | fire;
    end else begin : g_norep
      assign pulse_d = press;
    end

    assign level[g] = deb_q;
    assign pulse[g] = pulse_q;
  end

  assign bus.btn_level              = level;
  assign bus.set_mode_button_export = pulse[3];
  assign bus.inc_hour_button_export = pulse[2];
  assign bus.inc_min_button_export  = pulse[1];
  assign bus.confirm_button_export  = pulse[0];

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: directed scenarios plus random key activity, compared each cycle
// against a window-based debounce and arithmetic pulse-schedule model.
module tb_button_conditioner;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_n;
  logic [3:0] dut_pulse;

  button_conditioner_if bus_if ();

  assign bus_if.set_mode_key_n = key_n[3];
  assign bus_if.inc_hour_key_n = key_n[2];
  assign bus_if.inc_min_key_n  = key_n[1];
  assign bus_if.confirm_key_n  = key_n[0];
  assign dut_pulse = {bus_if.set_mode_button_export, bus_if.inc_hour_button_export,
                      bus_if.inc_min_button_export, bus_if.confirm_button_export};

  button_conditioner #(
    .CLK_HZ          (1000),
    .DEBOUNCE_MS     (4),
    .REPEAT_DELAY_MS (20),
    .REPEAT_RATE_MS  (5)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: pressed samples per edge, debounced level, edge of last rise.
  int  edge_n;
  bit  hist[4][64];
  bit  lvl[4];
  int  rise[4];
  int  seen[4];
  int  last_edge[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit synced(int k, int e);
    return (e > 2) ? hist[k][(e - 2) % 64] : 1'b0;
  endfunction

  task automatic model_reset();
    edge_n = 0;
    for (int k = 0; k < 4; k++) begin
      lvl[k]  = 1'b0;
      rise[k] = 0;
      for (int i = 0; i < 64; i++) hist[k][i] = 1'b0;
    end
  endtask

  task automatic clear_seen();
    for (int k = 0; k < 4; k++) begin
      seen[k]      = 0;
      last_edge[k] = 0;
    end
  endtask

  task automatic tick();
    logic [3:0] exp_lvl;
    logic [3:0] exp_pulse;
    @(posedge clk);
    #1;
    edge_n++;
    for (int k = 0; k < 4; k++) hist[k][edge_n % 64] = ~key_n[k];
    for (int k = 0; k < 4; k++) begin
      bit toggle = 1'b1;
      int off;
      // Level flips once the last DB synchronized samples all disagree with it.
      for (int j = 0; j < DB; j++) begin
        if (edge_n - j < 1 || synced(k, edge_n - j) == lvl[k]) toggle = 1'b0;
      end
      if (toggle) begin
        lvl[k] = ~lvl[k];
        if (lvl[k]) rise[k] = edge_n;
      end
      exp_lvl[k]   = lvl[k];
      exp_pulse[k] = 1'b0;
      if (lvl[k] && rise[k] > 0) begin
        off = edge_n - (rise[k] + 1);
        if (off == 0) exp_pulse[k] = 1'b1;
        else if ((k == 1 || k == 2) && off >= RD && (off - RD) % RR == 0)
          exp_pulse[k] = 1'b1;
      end
    end
    check($sformatf("level@%0d", edge_n), 32'(bus_if.btn_level), 32'(exp_lvl));
    check($sformatf("pulse@%0d", edge_n), 32'(dut_pulse), 32'(exp_pulse));
    for (int k = 0; k < 4; k++) begin
      if (dut_pulse[k]) begin
        seen[k]++;
        last_edge[k] = edge_n;
      end
    end
  endtask

  // Asserts reset mid-cycle, checks outputs clear without a clock, releases on a negedge.
  task automatic do_reset(input int cycles);
    #3 rst_n = 1'b0;
    #1 check("rst_async", 32'({dut_pulse, bus_if.btn_level}), 32'd0);
    repeat (cycles) begin
      @(posedge clk);
      #1 check("rst_hold", 32'({dut_pulse, bus_if.btn_level}), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  int base;
  int left[4];

  initial begin
    key_n = 4'hF;
    rst_n = 1'b0;
    model_reset();
    clear_seen();
    do_reset(3);
    repeat (5) tick();

    // Clean confirm press and release.
    clear_seen();
    base = edge_n;
    key_n[0] = 1'b0;
    repeat (12) tick();
    check("cfm_count", 32'(seen[0]), 32'd1);
    check("cfm_edge", 32'(last_edge[0] - base), 32'd7);
    key_n[0] = 1'b1;
    repeat (12) tick();
    check("cfm_no_release_pulse", 32'(seen[0]), 32'd1);

    // Bouncing inc_min, then settled low.
    clear_seen();
    for (int i = 0; i < 5; i++) begin
      key_n[1] = 1'b0;
      repeat (2) tick();
      key_n[1] = 1'b1;
      repeat (2) tick();
    end
    base = edge_n;
    key_n[1] = 1'b0;
    repeat (12) tick();
    check("bounce_count", 32'(seen[1]), 32'd1);
    check("bounce_edge", 32'(last_edge[1] - base), 32'd7);
    key_n[1] = 1'b1;
    repeat (10) tick();

    // Short glitch ignored.
    clear_seen();
    key_n[1] = 1'b0;
    repeat (3) tick();
    key_n[1] = 1'b1;
    repeat (10) tick();
    check("glitch_count", 32'(seen[1]), 32'd0);

    // Auto-repeat: release lands after T+40, before T+45.
    clear_seen();
    key_n[1] = 1'b0;
    repeat (42) tick();
    key_n[1] = 1'b1;
    repeat (20) tick();
    check("repeat_count", 32'(seen[1]), 32'd6);

    // All four keys together.
    clear_seen();
    key_n = 4'h0;
    repeat (60) tick();
    check("all_set_mode", 32'(seen[3]), 32'd1);
    check("all_confirm", 32'(seen[0]), 32'd1);
    check("all_inc_min", 32'(seen[1]), 32'd8);
    check("all_lockstep", 32'(seen[2]), 32'(seen[1]));
    key_n = 4'hF;
    repeat (10) tick();

    // Reset during inc_hour auto-repeat, key still held.
    key_n[2] = 1'b0;
    repeat (35) tick();
    do_reset(3);
    clear_seen();
    repeat (30) tick();
    check("rst_hold_count", 32'(seen[2]), 32'd2);
    check("rst_hold_last", 32'(last_edge[2]), 32'd27);
    key_n = 4'hF;
    repeat (10) tick();

    // Random activity, mixing glitches and long holds.
    for (int k = 0; k < 4; k++) left[k] = 0;
    repeat (1500) begin
      for (int k = 0; k < 4; k++) begin
        if (left[k] == 0) begin
          key_n[k] = ~key_n[k];
          left[k]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6))
                                                  : int'($urandom_range(4, 50));
        end else begin
          left[k]--;
        end
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
